// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter -- two-master Wishbone classic bus arbiter.
//
// Purpose:
//   Grants one shared Wishbone bus to master 0 or master 1. A grant lasts as
//   long as the owner keeps cyc high (no preemption). Every release passes
//   through IDLE for one cycle. Contention in IDLE goes to the master that did
//   not own the bus last (strict alternation). After reset, master 0 wins the
//   first contention. Request signals reach the bus combinationally, so a
//   granted master sees no added latency.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   A 16-bit watchdog counts unacknowledged strobe cycles of the owner. When
//   it reaches TIMEOUT_CYCLES, the owner gets a one-cycle err, stb_o is forced
//   low for that cycle and the counter restarts. Without the macro there is no
//   counter, and err_o only ever mirrors err_i.
//
// Parameters:
//   TIMEOUT_CYCLES  unacked strobe cycles before the watchdog fires (1..65535)
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i            master N bus controls (N = 0, 1)
//   mN_adr_i/dat_i/sel_i           master N address, write data, byte selects
//   mN_ack_o/err_o/dat_o           response to master N
//   cyc_o/stb_o/we_o               shared bus controls
//   adr_o/dat_o/sel_o              shared address, write data, byte selects
//   ack_i/err_i/dat_i              shared slave response
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  // Last owner: 1'b1 after reset so master 0 wins the first contention.
  logic   last_q, last_d;
  logic   timeout_fire_s;

  // Reject out-of-range timeout settings at elaboration time.
  if (TIMEOUT_CYCLES < 32'd1 || TIMEOUT_CYCLES > 32'd65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  // Next-state and last-owner logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Contention: grant whichever master did not own the bus last.
          if (last_q) begin
            state_d = OWN0;
          end else begin
            state_d = OWN1;
          end
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else begin
          state_d = OWN1;
        end
      end
      default: begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
    endcase
  end

  // State and last-owner registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wdog_q, wdog_d;
  logic        own_stb_s;

  // Strobe of the current owner, before any watchdog masking.
  always_comb begin
    own_stb_s = 1'b0;
    case (state_q)
      OWN0:    own_stb_s = m0_stb_i;
      OWN1:    own_stb_s = m1_stb_i;
      default: own_stb_s = 1'b0;
    endcase
  end

  assign timeout_fire_s = own_stb_s && (wdog_q == TIMEOUT_LIMIT);

  // Watchdog next value: count unanswered strobes, restart on any response,
  // on firing, or whenever the bus is not (or no longer) owned.
  always_comb begin
    wdog_d = wdog_q;
    if ((state_q == IDLE) || (state_d == IDLE) || ack_i || err_i || timeout_fire_s) begin
      wdog_d = 16'h0000;
    end else if (own_stb_s) begin
      wdog_d = wdog_q + 16'h0001;
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= 16'h0000;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_fire_s = 1'b0;
`endif

  // Bus multiplexing and response routing; everything is zero in IDLE and the
  // non-owner never sees ack/err. On a watchdog fire the strobe is withheld,
  // so any ack arriving that cycle does not belong to a real transfer.
  always_comb begin
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    we_o     = 1'b0;
    adr_o    = 32'h0000_0000;
    dat_o    = 32'h0000_0000;
    sel_o    = 4'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      OWN0: begin
        cyc_o    = m0_cyc_i;
        stb_o    = m0_stb_i & ~timeout_fire_s;
        we_o     = m0_we_i;
        adr_o    = m0_adr_i;
        dat_o    = m0_dat_i;
        sel_o    = m0_sel_i;
        m0_ack_o = ack_i & ~timeout_fire_s;
        m0_err_o = err_i | timeout_fire_s;
      end
      OWN1: begin
        cyc_o    = m1_cyc_i;
        stb_o    = m1_stb_i & ~timeout_fire_s;
        we_o     = m1_we_i;
        adr_o    = m1_adr_i;
        dat_o    = m1_dat_i;
        sel_o    = m1_sel_i;
        m1_ack_o = ack_i & ~timeout_fire_s;
        m1_err_o = err_i | timeout_fire_s;
      end
      default: begin
        cyc_o = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; masters qualify it with their ack.
  assign m0_dat_o = dat_i;
  assign m1_dat_o = dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter -- self-checking bench for wb_arbiter.
// A table of one-cycle vectors covers grants, routing, release and contention;
// hand-written sequences cover reset, alternation, hold-off, async abort and
// the watchdog (or its absence when WB_ARB_TIMEOUT_EN is undefined).
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0000;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic m0_cyc_i, m0_stb_i, m0_we_i;
  logic m1_cyc_i, m1_stb_i, m1_we_i;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic ack_i, err_i;
  logic [31:0] dat_i;
  logic [1:0] own_s;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(A0), .m0_dat_i(D0), .m0_sel_i(S0),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(A1), .m1_dat_i(D1), .m1_sel_i(S1),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
  );

  // Which master's address/data/selects are on the bus: 0 none, 3 garbage.
  assign own_s = (adr_o == A0 && dat_o == D0 && sel_o == S0) ? 2'd1 :
                 (adr_o == A1 && dat_o == D1 && sel_o == S1) ? 2'd2 :
                 (adr_o == 32'h0 && dat_o == 32'h0 && sel_o == 4'h0) ? 2'd0 : 2'd3;

  typedef struct packed {
    logic [7:0] in;   // {c0,s0,w0,c1,s1,w1,ack,err}
    logic [8:0] exp;  // {cyc,stb,we,own[1:0],ack0,ack1,err0,err1}
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply(input logic [7:0] v);
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, ack_i, err_i} = v;
  endtask

  task automatic reset_pulse();
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic logic [8:0] actual_vec();
    return {cyc_o, stb_o, we_o, own_s, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int err_seen;
    rst_ni = 1'b0;
    dat_i  = RD;
    apply(8'b110_110_10);
    // Reset: outputs idle even with requests and a slave ack present.
    @(negedge clk_i);
    check("reset_outputs", 32'(actual_vec()), 32'h0);
    apply(8'b000_000_00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    vecs[0]  = {8'b110_000_00, 9'b000_00_0000};  // IDLE, m0 requests
    vecs[1]  = {8'b110_000_00, 9'b110_01_0000};  // grant at cycle 1
    vecs[2]  = {8'b110_000_00, 9'b110_01_0000};
    vecs[3]  = {8'b110_000_10, 9'b110_01_1000};  // ack after 2 cycles
    vecs[4]  = {8'b000_000_00, 9'b000_01_0000};  // m0 releases
    vecs[5]  = {8'b110_111_00, 9'b000_00_0000};  // IDLE, contention, last=0
    vecs[6]  = {8'b110_111_00, 9'b111_10_0000};  // m1 owns
    vecs[7]  = {8'b110_111_10, 9'b111_10_0100};  // ack routed to m1 only
    vecs[8]  = {8'b110_111_01, 9'b111_10_0001};  // err routed to m1 only
    vecs[9]  = {8'b110_000_00, 9'b000_10_0000};  // m1 releases
    vecs[10] = {8'b110_000_00, 9'b000_00_0000};  // IDLE gap, m0 waiting
    vecs[11] = {8'b000_000_10, 9'b000_01_1000};  // release with ack
    vecs[12] = {8'b000_000_00, 9'b000_00_0000};
    vecs[13] = {8'b000_000_10, 9'b000_00_0000};  // stray ack in IDLE

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].in);
      @(negedge clk_i);
      check($sformatf("vec%0d", i), 32'(actual_vec()), 32'(vecs[i].exp));
      if (i == 3) begin
        check("vec3_m0_dat", m0_dat_o, RD);
        check("vec3_m1_dat", m1_dat_o, RD);
      end
      tick();
    end

    // Simultaneous requests right after reset: m0, gap, m1, then m0 again.
    apply(8'b110_110_00);
    reset_pulse();
    tick();
    @(negedge clk_i);
    check("alt_first_m0", 32'({cyc_o, own_s}), 32'({1'b1, 2'd1}));
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("alt_idle_gap", 32'({cyc_o, own_s}), 32'({1'b0, 2'd0}));
    tick();
    @(negedge clk_i);
    check("alt_then_m1", 32'({cyc_o, own_s}), 32'({1'b1, 2'd2}));
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("alt_again_m0", 32'({cyc_o, own_s}), 32'({1'b1, 2'd1}));

    // m1 held off through five acked m0 strobes; granted 2 cycles after drop.
    apply(8'b000_000_00);
    reset_pulse();
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; ack_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check($sformatf("hold_acks%0d", k), 32'({m0_ack_o, m1_ack_o}), 32'(2'b10));
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; ack_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("hold_idle", 32'({cyc_o, own_s, m1_ack_o}), 32'({1'b0, 2'd0, 1'b0}));
    tick();
    @(negedge clk_i);
    check("hold_grant_m1", 32'({cyc_o, stb_o, own_s}), 32'({1'b1, 1'b1, 2'd2}));

    // Asynchronous reset during OWN1 with stb high aborts immediately.
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_abort", 32'({cyc_o, stb_o, m1_ack_o}), 32'(3'b000));
    ack_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_reset_no_ack", 32'({m1_ack_o, cyc_o}), 32'(2'b00));
    tick();
    @(negedge clk_i);
    check("post_reset_regrant", 32'({m1_ack_o, own_s}), 32'({1'b1, 2'd2}));

    // Watchdog behaviour, or plain err pass-through without it.
    apply(8'b000_000_00);
    reset_pulse();
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check($sformatf("wdog_cyc%0d", k), 32'({stb_o, m0_err_o, m1_err_o}),
            32'({(k != 4), (k == 4), 1'b0}));
      tick();
    end
`else
    err_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (m0_err_o || m1_err_o) err_seen++;
      tick();
    end
    check("no_wdog_err", 32'(err_seen), 32'd0);
    err_i = 1'b1;
    @(negedge clk_i);
    check("err_mirror_on", 32'({m0_err_o, m1_err_o, stb_o}), 32'(3'b101));
    tick();
    err_i = 1'b0;
    @(negedge clk_i);
    check("err_mirror_off", 32'({m0_err_o, m1_err_o}), 32'(2'b00));
`endif

    apply(8'b000_000_00);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of unacknowledged strobe cycles before the watchdog fires (range 1..65535).
REQ-002 clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 mN_cyc_i  input  1  master N (N=0,1) bus cycle request.
REQ-005 mN_stb_i  input  1  master N strobe.
REQ-006 mN_we_i  input  1  master N write enable.
REQ-007 mN_adr_i  input  32  master N byte address.
REQ-008 mN_dat_i  input  32  master N write data.
REQ-009 mN_sel_i  input  4  master N byte selects.
REQ-010 mN_ack_o  output  1  acknowledge to master N.
REQ-011 mN_err_o  output  1  error to master N.
REQ-012 mN_dat_o  output  32  read data to master N.
REQ-013 cyc_o, stb_o, we_o  output  1 each  shared-bus controls.
REQ-014 adr_o  output  32  shared address; drives the address decoder input.
REQ-015 dat_o  output  32  shared write data.
REQ-016 sel_o  output  4  shared byte selects.
REQ-017 ack_i, err_i  input  1 each  shared-bus slave response.
REQ-018 dat_i  input  32  shared-bus read data.

Function
REQ-019 FSM states: IDLE, OWN0, OWN1; state, last-owner flag (last_q), and watchdog counter are registered.
REQ-020 In IDLE, only m0_cyc_i high -> OWN0 next cycle; only m1_cyc_i high -> OWN1; both high -> the master not equal to last_q; neither -> stay IDLE.
REQ-021 In IDLE, cyc_o, stb_o, we_o = 0; adr_o, dat_o, sel_o = 0; all mN_ack_o/mN_err_o = 0.
REQ-022 In OWNx, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o combinationally equal master x's inputs (zero added latency).
REQ-023 In OWNx, mx_ack_o = ack_i, mx_err_o = err_i, mx_dat_o = dat_i; the non-owner's ack/err = 0 at all times.
REQ-024 mN_dat_o = dat_i for both masters unconditionally (qualified by ack).
REQ-025 In OWNx, when mx_cyc_i = 0 -> IDLE next cycle and last_q <= x; ownership is never preempted while mx_cyc_i = 1.
REQ-026 A release always passes through IDLE for one cycle; no back-to-back handover.
REQ-027 A request from the non-owner during OWNx is held off (no ack/err) until granted; it is never lost.
REQ-028 Owner releasing cyc in the same cycle its ack arrives: ack is delivered, then IDLE.

Reset
REQ-029 While rst_ni = 0: state = IDLE, last_q = 1 (so m0 wins the first contention), watchdog counter = 0, all outputs at REQ-021 values.
REQ-030 Reset asserted mid-cycle aborts the transfer immediately; no ack/err is issued for it after deassertion.
REQ-031 First grant possible on the first rising edge after rst_ni deasserts.

Configuration
REQ-032 Macro WB_ARB_TIMEOUT_EN defined: 16-bit counter increments each cycle in OWNx with stb_o = 1 and ack_i = err_i = 0; clears on ack_i, err_i, or leaving OWNx.
REQ-033 With WB_ARB_TIMEOUT_EN, when the counter equals TIMEOUT_CYCLES, mx_err_o = 1 for that one cycle, stb_o is forced 0 that cycle, and the counter clears.
REQ-034 Without WB_ARB_TIMEOUT_EN, no counter exists, TIMEOUT_CYCLES is unused, and err is only ever passed through from err_i.

Verification
REQ-035 Reset, then m0 read adr 0x0000_1000, ack_i after 2 cycles with dat_i = 0xDEAD_BEEF -> grant at cycle 1, adr_o = 0x0000_1000, m0_ack_o pulses, m0_dat_o = 0xDEAD_BEEF, m1_ack_o = 0.
REQ-036 Both cyc raised same cycle after reset -> m0 owns first; after m0 release, IDLE one cycle, then m1 owns; repeat contention -> m0 again (strict alternation).
REQ-037 m1 requests while m0 holds cyc for 5 back-to-back acked strobes -> m1 sees no ack for all 5, is granted 2 cycles after m0 drops cyc.
REQ-038 rst_ni low during OWN1 with stb high -> cyc_o = 0 asynchronously; after release, m1_ack_o stays 0 until a new grant.
REQ-039 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave never acks -> m0_err_o high exactly one cycle, 4 cycles after stb_o rises, with stb_o = 0 that cycle.
REQ-040 Without WB_ARB_TIMEOUT_EN, same stimulus for 1000 cycles -> no mN_err_o assertion; err_i = 1 pulse -> owner's err_o mirrors it exactly.
